// File: rtl/stage_mem_sized.sv
// Pipeline memory stage: byte/halfword/word loads and stores with lane steering,
// sign/zero extension, misalignment exceptions and an MMU-busy timeout.
module stage_mem_sized #(
    parameter int REGADDR_WIDTH = 5,
    parameter int TIMEOUT       = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [REGADDR_WIDTH-1:0] ex_reg_addr,
    input  logic [31:0]              ex_alu_result,
    input  logic [3:0]               ex_mem_op,
    input  logic [31:0]              ex_mem_addr,
    input  logic [31:0]              ex_mem_data,
    output logic [REGADDR_WIDTH-1:0] wb_reg_addr,
    output logic [31:0]              wb_reg_data,
    output logic                     set_stall,
    output logic                     exc_valid,
    output logic [1:0]               exc_code,
    output logic [31:0]              exc_badaddr,
    output logic [31:0]              mmu_addr,
    input  logic [31:0]              mmu_data_in,
    output logic [31:0]              mmu_data_out,
    output logic [1:0]               mmu_opt,
    output logic [3:0]               mmu_be,
    input  logic                     mmu_busy
);

    localparam logic [3:0] OP_LW  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LB  = 4'd4;
    localparam logic [3:0] OP_LBU = 4'd5;
    localparam logic [3:0] OP_SW  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SB  = 4'd8;

    localparam logic [1:0] OPT_NONE  = 2'd0;
    localparam logic [1:0] OPT_READ  = 2'd1;
    localparam logic [1:0] OPT_WRITE = 2'd2;

    localparam logic [1:0] EXC_LOAD    = 2'd1;
    localparam logic [1:0] EXC_STORE   = 2'd2;
    localparam logic [1:0] EXC_TIMEOUT = 2'd3;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        READY       = 2'd0,
        WAIT_UNBUSY = 2'd1,
        SLEEP       = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [15:0]              cnt_q, cnt_d;
    logic [3:0]               op_q, op_d;
    logic [31:0]              addr_q, addr_d;
    logic [REGADDR_WIDTH-1:0] dest_q, dest_d;

    logic [REGADDR_WIDTH-1:0] wb_reg_addr_d;
    logic [31:0]              wb_reg_data_d;
    logic                     exc_valid_d;
    logic [1:0]               exc_code_d;
    logic [31:0]              exc_badaddr_d;
    logic [31:0]              mmu_addr_d;
    logic [31:0]              mmu_data_out_d;
    logic [1:0]               mmu_opt_d;
    logic [3:0]               mmu_be_d;

    logic        ex_is_load, ex_is_store, ex_misaligned;
    logic [31:0] st_data;
    logic [3:0]  st_be;
    logic        op_q_is_load;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_value;

    assign set_stall = (state_q != READY);

    // Decode and store steering for the op presented by EX.
    always_comb begin
        ex_is_load    = (ex_mem_op >= OP_LW) && (ex_mem_op <= OP_LBU);
        ex_is_store   = (ex_mem_op >= OP_SW) && (ex_mem_op <= OP_SB);
        ex_misaligned = 1'b0;
        st_data       = ex_mem_data;
        st_be         = 4'b1111;
        case (ex_mem_op)
            OP_LW, OP_SW:         ex_misaligned = |ex_mem_addr[1:0];
            OP_LH, OP_LHU, OP_SH: ex_misaligned = ex_mem_addr[0];
            default:              ex_misaligned = 1'b0;
        endcase
        case (ex_mem_op)
            OP_SH: begin
                st_data = {2{ex_mem_data[15:0]}};
                st_be   = 4'b0011 << ex_mem_addr[1:0];
            end
            OP_SB: begin
                st_data = {4{ex_mem_data[7:0]}};
                st_be   = 4'b0001 << ex_mem_addr[1:0];
            end
            default: begin
                st_data = ex_mem_data;
                st_be   = 4'b1111;
            end
        endcase
    end

    // Lane extraction for the load in flight, using the latched low address bits.
    always_comb begin
        op_q_is_load = (op_q >= OP_LW) && (op_q <= OP_LBU);
        ld_byte      = mmu_data_in[{addr_q[1:0], 3'b000} +: 8];
        ld_half      = mmu_data_in[{addr_q[1], 4'b0000} +: 16];
        case (op_q)
            OP_LH:   ld_value = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_value = {16'd0, ld_half};
            OP_LB:   ld_value = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_value = {24'd0, ld_byte};
            default: ld_value = mmu_data_in;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        op_d           = op_q;
        addr_d         = addr_q;
        dest_d         = dest_q;
        wb_reg_addr_d  = wb_reg_addr;
        wb_reg_data_d  = wb_reg_data;
        exc_valid_d    = 1'b0;
        exc_code_d     = exc_code;
        exc_badaddr_d  = exc_badaddr;
        mmu_addr_d     = mmu_addr;
        mmu_data_out_d = mmu_data_out;
        mmu_opt_d      = OPT_NONE;
        mmu_be_d       = mmu_be;
        case (state_q)
            READY: begin
                if (!ex_is_load && !ex_is_store) begin
                    wb_reg_addr_d = ex_reg_addr;
                    wb_reg_data_d = ex_alu_result;
                end else if (ex_misaligned) begin
                    wb_reg_addr_d = '0;
                    exc_valid_d   = 1'b1;
                    exc_code_d    = ex_is_load ? EXC_LOAD : EXC_STORE;
                    exc_badaddr_d = ex_mem_addr;
                end else begin
                    mmu_opt_d     = ex_is_load ? OPT_READ : OPT_WRITE;
                    mmu_addr_d    = {ex_mem_addr[31:2], 2'b00};
                    mmu_be_d      = ex_is_load ? 4'b1111 : st_be;
                    if (ex_is_store) mmu_data_out_d = st_data;
                    wb_reg_addr_d = '0;
                    dest_d        = ex_reg_addr;
                    op_d          = ex_mem_op;
                    addr_d        = ex_mem_addr;
                    cnt_d         = '0;
                    state_d       = WAIT_UNBUSY;
                end
            end
            WAIT_UNBUSY: begin
                if (!mmu_busy) begin
                    if (op_q_is_load) begin
                        wb_reg_data_d = ld_value;
                        wb_reg_addr_d = dest_q;
                    end
                    state_d = SLEEP;
                end else if (cnt_q == CNT_LAST) begin
                    // MMU never answered: give up with a bus error rather than hang.
                    exc_valid_d   = 1'b1;
                    exc_code_d    = EXC_TIMEOUT;
                    exc_badaddr_d = addr_q;
                    wb_reg_addr_d = '0;
                    state_d       = SLEEP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            SLEEP:   state_d = READY;
            default: state_d = READY;
        endcase
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            state_q      <= READY;
            cnt_q        <= '0;
            op_q         <= '0;
            addr_q       <= '0;
            dest_q       <= '0;
            wb_reg_addr  <= '0;
            wb_reg_data  <= '0;
            exc_valid    <= 1'b0;
            exc_code     <= '0;
            exc_badaddr  <= '0;
            mmu_addr     <= '0;
            mmu_data_out <= '0;
            mmu_opt      <= OPT_NONE;
            mmu_be       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            dest_q       <= dest_d;
            wb_reg_addr  <= wb_reg_addr_d;
            wb_reg_data  <= wb_reg_data_d;
            exc_valid    <= exc_valid_d;
            exc_code     <= exc_code_d;
            exc_badaddr  <= exc_badaddr_d;
            mmu_addr     <= mmu_addr_d;
            mmu_data_out <= mmu_data_out_d;
            mmu_opt      <= mmu_opt_d;
            mmu_be       <= mmu_be_d;
        end
    end

endmodule

// File: tb/tb_stage_mem_sized.sv
// Randomized scoreboard bench for stage_mem_sized: the driver pushes expected MMU
// requests, exceptions, writebacks and stall lengths; a monitor pops and compares.
`timescale 1ns/1ps
module tb_stage_mem_sized;

    localparam int TO = 4;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] ex_reg_addr;
    logic [31:0]   ex_alu_result;
    logic [3:0]    ex_mem_op;
    logic [31:0]   ex_mem_addr;
    logic [31:0]   ex_mem_data;
    logic [RW-1:0] wb_reg_addr;
    logic [31:0]   wb_reg_data;
    logic          set_stall;
    logic          exc_valid;
    logic [1:0]    exc_code;
    logic [31:0]   exc_badaddr;
    logic [31:0]   mmu_addr;
    logic [31:0]   mmu_data_in;
    logic [31:0]   mmu_data_out;
    logic [1:0]    mmu_opt;
    logic [3:0]    mmu_be;
    logic          mmu_busy;

    always #5 clk = ~clk;

    stage_mem_sized #(.REGADDR_WIDTH(RW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ex_reg_addr(ex_reg_addr), .ex_alu_result(ex_alu_result),
        .ex_mem_op(ex_mem_op), .ex_mem_addr(ex_mem_addr), .ex_mem_data(ex_mem_data),
        .wb_reg_addr(wb_reg_addr), .wb_reg_data(wb_reg_data), .set_stall(set_stall),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_badaddr(exc_badaddr),
        .mmu_addr(mmu_addr), .mmu_data_in(mmu_data_in), .mmu_data_out(mmu_data_out),
        .mmu_opt(mmu_opt), .mmu_be(mmu_be), .mmu_busy(mmu_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [69:0] req_q[$];    // {opt, word addr, store data, be}
    logic [33:0] exc_q[$];    // {code, badaddr}
    logic [36:0] wb_q[$];     // {dest, data}
    logic [15:0] stall_q[$];  // cycles of set_stall per access

    logic        mon_en = 1'b0;
    logic [69:0] req_item;
    logic [33:0] exc_item;
    logic [36:0] wb_item;
    logic [RW-1:0] prev_wb = '0;
    int          run_len = 0;

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] addr,
                                             input logic [31:0] w);
        logic [31:0] v;
        v = w >> (8 * (addr % 4));
        case (op)
            4'd2:    return ((v & 32'hFFFF) ^ 32'h8000) - 32'h8000;
            4'd3:    return v & 32'hFFFF;
            4'd4:    return ((v & 32'hFF) ^ 32'h80) - 32'h80;
            4'd5:    return v & 32'hFF;
            default: return w;
        endcase
    endfunction

    // Monitor: every visible DUT event must match the head of its queue.
    always @(posedge clk) begin
        if (mon_en) begin
            if (mmu_opt != 2'd0) begin
                if (req_q.size() == 0) check("req_unexpected", mmu_opt, 70'd0);
                else begin
                    req_item = req_q.pop_front();
                    check("mmu_opt", mmu_opt, req_item[69:68]);
                    check("mmu_addr", mmu_addr, req_item[67:36]);
                    check("mmu_be", mmu_be, req_item[3:0]);
                    if (req_item[69:68] == 2'd2) check("mmu_data_out", mmu_data_out, req_item[35:4]);
                end
            end
            if (exc_valid) begin
                if (exc_q.size() == 0) check("exc_unexpected", exc_valid, 70'd0);
                else begin
                    exc_item = exc_q.pop_front();
                    check("exc_code", exc_code, exc_item[33:32]);
                    check("exc_badaddr", exc_badaddr, exc_item[31:0]);
                end
            end
            if (wb_reg_addr != '0 && prev_wb == '0) begin
                if (wb_q.size() == 0) check("wb_unexpected", wb_reg_addr, 70'd0);
                else begin
                    wb_item = wb_q.pop_front();
                    check("wb_reg_addr", wb_reg_addr, wb_item[36:32]);
                    check("wb_reg_data", wb_reg_data, wb_item[31:0]);
                end
            end
            if (set_stall) run_len++;
            else if (run_len > 0) begin
                if (stall_q.size() == 0) check("stall_unexpected", run_len, 70'd0);
                else check("stall_cycles", run_len, stall_q.pop_front());
                run_len = 0;
            end
        end
        prev_wb = wb_reg_addr;
    end

    task automatic check_reset(input string tag);
        check({tag, "_wb_reg_addr"}, wb_reg_addr, 70'd0);
        check({tag, "_wb_reg_data"}, wb_reg_data, 70'd0);
        check({tag, "_set_stall"}, set_stall, 70'd0);
        check({tag, "_mmu_opt"}, mmu_opt, 70'd0);
        check({tag, "_mmu_addr"}, mmu_addr, 70'd0);
        check({tag, "_mmu_data_out"}, mmu_data_out, 70'd0);
        check({tag, "_mmu_be"}, mmu_be, 70'd0);
        check({tag, "_exc_valid"}, exc_valid, 70'd0);
        check({tag, "_exc_code"}, exc_code, 70'd0);
        check({tag, "_exc_badaddr"}, exc_badaddr, 70'd0);
    endtask

    // Issue one op, model its effects, play the MMU (busy for nbusy WAIT edges).
    task automatic do_op(input logic [3:0] op, input logic [RW-1:0] dest, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [31:0] alu,
                         input logic [31:0] rdata, input int nbusy);
        bit          is_load, is_store, aligned, issued;
        int          size, k;
        logic [31:0] word, sd;
        logic [3:0]  be;
        is_load  = (op >= 4'd1) && (op <= 4'd5);
        is_store = (op >= 4'd6) && (op <= 4'd8);
        size     = (op == 4'd1 || op == 4'd6) ? 4 : (op == 4'd2 || op == 4'd3 || op == 4'd7) ? 2 : 1;
        aligned  = (addr % size) == 0;
        issued   = (is_load || is_store) && aligned;
        word     = addr - (addr % 4);
        if (!is_load && !is_store) begin
            if (dest != '0) wb_q.push_back({dest, alu});
        end else if (!aligned) begin
            exc_q.push_back({is_load ? 2'd1 : 2'd2, addr});
        end else begin
            if (is_load) req_q.push_back({2'd1, word, 32'd0, 4'hF});
            else begin
                if (size == 4) begin
                    sd = sdata;
                    be = 4'hF;
                end else if (size == 2) begin
                    sd = (sdata & 32'hFFFF) * 32'h0001_0001;
                    be = 4'(3 << (addr % 4));
                end else begin
                    sd = (sdata & 32'hFF) * 32'h0101_0101;
                    be = 4'(1 << (addr % 4));
                end
                req_q.push_back({2'd2, word, sd, be});
            end
            if (nbusy >= TO) begin
                exc_q.push_back({2'd3, addr});
                stall_q.push_back(16'(TO + 1));
            end else begin
                stall_q.push_back(16'(nbusy + 2));
                if (is_load && dest != '0) wb_q.push_back({dest, ref_load(op, addr, rdata)});
            end
        end

        @(posedge clk); #1;
        ex_mem_op     = op;
        ex_reg_addr   = dest;
        ex_mem_addr   = addr;
        ex_mem_data   = sdata;
        ex_alu_result = alu;
        mmu_data_in   = rdata;
        mmu_busy      = issued && (nbusy > 0);
        @(negedge clk); #1;
        ex_mem_op   = 4'd0;
        ex_reg_addr = '0;
        if (issued) begin
            for (int i = 0; i < nbusy; i++) @(negedge clk);
            #1 mmu_busy = 1'b0;
            k = 0;
            @(posedge clk);
            while (set_stall === 1'b1 && k < 60) begin
                @(posedge clk);
                k++;
            end
            check("stall_release", set_stall, 70'd0);
        end
        mmu_busy = 1'b0;
        @(negedge clk); #1;  // idle edge between ops keeps writeback events distinct
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        ex_reg_addr = '0; ex_alu_result = '0; ex_mem_op = '0; ex_mem_addr = '0; ex_mem_data = '0;
        mmu_data_in = '0; mmu_busy = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        check_reset("init");
        #1 rst = 1'b0;
        mon_en = 1'b1;

        do_op(4'd0, 5'd3, 32'h0, 32'h0, 32'h1234, 32'h0, 0);
        do_op(4'd4, 5'd5, 32'h103, 32'h0, 32'h0, 32'h80FF_0000, 2);
        do_op(4'd5, 5'd6, 32'h103, 32'h0, 32'h0, 32'h80FF_0000, 2);
        do_op(4'd7, 5'd7, 32'h202, 32'hABCD_1234, 32'h0, 32'h0, 0);
        do_op(4'd1, 5'd8, 32'h301, 32'h0, 32'h0, 32'h0, 0);
        do_op(4'd8, 5'd8, 32'h603, 32'h0000_00A5, 32'h0, 32'h0, 1);
        do_op(4'd7, 5'd8, 32'h605, 32'h0, 32'h0, 32'h0, 0);
        do_op(4'd1, 5'd9, 32'h400, 32'h0, 32'h0, 32'hDEAD_BEEF, 6);
        do_op(4'd1, 5'd10, 32'h404, 32'h0, 32'h0, 32'h1357_9BDF, TO - 1);
        do_op(4'd2, 5'd12, 32'h40A, 32'h0, 32'h0, 32'h8001_7FFF, 0);
        do_op(4'd1, 5'd0, 32'h408, 32'h0, 32'h0, 32'h2468_ACE0, 1);
        do_op(4'd12, 5'd13, 32'h3, 32'h0, 32'hFEED_F00D, 32'h0, 0);

        // Reset during WAIT_UNBUSY abandons the access.
        req_q.push_back({2'd1, 32'h500, 32'd0, 4'hF});
        stall_q.push_back(16'd3);
        @(posedge clk); #1;
        ex_mem_op = 4'd1; ex_reg_addr = 5'd9; ex_mem_addr = 32'h500; mmu_busy = 1'b1;
        @(negedge clk); #1;
        ex_mem_op = 4'd0; ex_reg_addr = '0;
        @(negedge clk);
        @(negedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        check_reset("midrst");
        #1 rst = 1'b0;
        mmu_busy = 1'b0;
        do_op(4'd0, 5'd11, 32'h0, 32'h0, 32'hCAFE_0011, 32'h0, 0);

        for (int n = 0; n < 300; n++) begin
            do_op(4'($urandom_range(0, 15)), RW'($urandom_range(0, 31)), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom_range(0, TO + 1));
        end

        repeat (6) @(posedge clk);
        mon_en = 1'b0;
        check("req_q_drained", req_q.size(), 70'd0);
        check("exc_q_drained", exc_q.size(), 70'd0);
        check("wb_q_drained", wb_q.size(), 70'd0);
        check("stall_q_drained", stall_q.size(), 70'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
